// File: rtl/hb_ram_responder_if.sv
// HyperBus link between a HyperBus master and the RAM responder.
// Master drives CS#, CK, RST#, DQ and RWDS inputs; the responder drives DQ/RWDS back with enables.
// All signals are synchronous to the responder's system clock.
interface hb_ram_responder_if;
  logic       hb_rstn_i;
  logic       hb_csn_i;
  logic       hb_clk_i;
  logic [7:0] hb_dq_i;
  logic [7:0] hb_dq_o;
  logic       hb_dq_oe;
  logic       hb_rwds_i;
  logic       hb_rwds_o;
  logic       hb_rwds_oe;

  modport master (
    output hb_rstn_i, hb_csn_i, hb_clk_i, hb_dq_i, hb_rwds_i,
    input  hb_dq_o, hb_dq_oe, hb_rwds_o, hb_rwds_oe
  );

  modport slave (
    input  hb_rstn_i, hb_csn_i, hb_clk_i, hb_dq_i, hb_rwds_i,
    output hb_dq_o, hb_dq_oe, hb_rwds_o, hb_rwds_oe
  );
endinterface

// File: rtl/hb_ram_responder.sv
// HyperBus RAM responder: CA decode, fixed 2x latency, linear/wrapped bursts on a 16-bit array, CR0/ID0 regs.
// Latency: outputs registered, they change on the clk edge that detects the CK edge; 2*LATENCY CK cycles initial latency.
// Backpressure: none; the master paces every byte with CK. HB_RESP_REG_EN enables the CR0/ID0 register space.
module hb_ram_responder #(
  parameter int          ADDR_BITS = 10,
  parameter int          LATENCY   = 6,
  parameter logic [15:0] ID0_VALUE = 16'h0C81,
  parameter logic [15:0] CR0_RESET = 16'h8F1F
) (
  input logic               clk,
  input logic               resetn,
  hb_ram_responder_if.slave hb
);

  typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_REGW, S_WDATA, S_RDATA} state_t;

  localparam int LAT_EDGES = 2 * LATENCY;
  localparam int LW        = $clog2(LAT_EDGES + 1);

  state_t               state, state_nxt;
  logic                 clr;
  logic                 ck_q, csn_q;
  logic                 rise, fall, edge_any, cs_fall;
  logic [39:0]          ca_q;
  logic [47:0]          ca_full;
  logic [31:0]          ca_waddr;
  logic                 ca_done, ca_regw, lat_done;
  logic [2:0]           byte_cnt;
  logic [LW-1:0]        lat_cnt;
  logic [ADDR_BITS-1:0] addr, addr_next;
  logic                 is_read, is_reg, is_lin;
  logic [7:0]           wr_hi;
  logic                 wr_hi_mask;
  logic [15:0]          rd_word;
  logic [15:0]          mem [0:2**ADDR_BITS-1];
  logic [7:0]           dq_o_q, dq_o_nxt;
  logic                 dq_oe_q, dq_oe_nxt, rwds_o_q, rwds_o_nxt, rwds_oe_q, rwds_oe_nxt;
  logic                 unused_ca;

`ifdef HB_RESP_REG_EN
  logic [15:0] cr0;
  logic [7:0]  reg_hi;
  logic        reg_done;
`else
  logic        unused_reg_params;
  assign unused_reg_params = ^{ID0_VALUE, CR0_RESET};
`endif

  // Either reset source returns the link logic to idle; the array is never cleared.
  assign clr      = ~resetn | ~hb.hb_rstn_i;
  assign rise     = hb.hb_clk_i & ~ck_q;
  assign fall     = ~hb.hb_clk_i & ck_q;
  assign edge_any = rise | fall;
  assign cs_fall  = ~hb.hb_csn_i & csn_q;

  // The sixth CA byte is still on DQ in its detect cycle, so decode from the live input.
  assign ca_full   = {ca_q, hb.hb_dq_i};
  assign ca_waddr  = {ca_full[44:16], ca_full[2:0]};
  assign ca_regw   = ~ca_full[47] & ca_full[46];
  assign ca_done   = (state == S_CA) && edge_any && (byte_cnt == 3'd5);
  assign lat_done  = (state == S_LAT) && fall && (lat_cnt == LW'(LAT_EDGES));
  assign unused_ca = ^{ca_waddr[31:ADDR_BITS], ca_full[15:3]};

  // Wrapped bursts stay inside their aligned 16-word group.
  assign addr_next = is_lin ? addr + ADDR_BITS'(1) : {addr[ADDR_BITS-1:4], addr[3:0] + 4'd1};

  assign hb.hb_dq_o     = dq_o_q;
  assign hb.hb_dq_oe    = dq_oe_q;
  assign hb.hb_rwds_o   = rwds_o_q;
  assign hb.hb_rwds_oe  = rwds_oe_q;

  // Read source: array for memory space, register file (or all-ones) for register space.
  always_comb begin
    rd_word = mem[addr];
    if (is_reg) begin
`ifdef HB_RESP_REG_EN
      rd_word = (addr == '0) ? ID0_VALUE : cr0;
`else
      rd_word = 16'hFFFF;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state; CS# high aborts any transfer.
  always_comb begin
    state_nxt = state;
    if (hb.hb_csn_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cs_fall)  state_nxt = S_CA;
        S_CA:    if (ca_done)  state_nxt = ca_regw ? S_REGW : S_LAT;
        S_LAT:   if (lat_done) state_nxt = is_read ? S_RDATA : S_WDATA;
        default: ;
      endcase
    end
  end

  // Next value of the registered DQ/RWDS outputs.
  always_comb begin
    dq_o_nxt    = dq_o_q;
    dq_oe_nxt   = dq_oe_q;
    rwds_o_nxt  = rwds_o_q;
    rwds_oe_nxt = rwds_oe_q;
    if (hb.hb_csn_i) begin
      dq_oe_nxt   = 1'b0;
      rwds_oe_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cs_fall) begin
          rwds_oe_nxt = 1'b1;
          rwds_o_nxt  = 1'b1;
        end
        S_CA:  if (ca_done && ca_regw) rwds_oe_nxt = 1'b0;
        S_LAT: if (lat_done && !is_read) rwds_oe_nxt = 1'b0;
        S_RDATA: begin
          if (rise) begin
            dq_o_nxt   = rd_word[15:8];
            rwds_o_nxt = 1'b1;
            dq_oe_nxt  = 1'b1;
          end else if (fall) begin
            dq_o_nxt   = rd_word[7:0];
            rwds_o_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      dq_o_q    <= 8'h00;
      dq_oe_q   <= 1'b0;
      rwds_o_q  <= 1'b0;
      rwds_oe_q <= 1'b0;
    end else begin
      dq_o_q    <= dq_o_nxt;
      dq_oe_q   <= dq_oe_nxt;
      rwds_o_q  <= rwds_o_nxt;
      rwds_oe_q <= rwds_oe_nxt;
    end
  end

  // Edge history, CA capture, latency count, burst address and write high-byte holding.
  always_ff @(posedge clk) begin
    ck_q  <= hb.hb_clk_i;
    csn_q <= hb.hb_csn_i;
    if (clr) begin
      ca_q       <= '0;
      byte_cnt   <= '0;
      lat_cnt    <= '0;
      addr       <= '0;
      is_read    <= 1'b0;
      is_reg     <= 1'b0;
      is_lin     <= 1'b0;
      wr_hi      <= 8'h00;
      wr_hi_mask <= 1'b1;
    end else if (!hb.hb_csn_i) begin
      case (state)
        S_IDLE: if (cs_fall) begin
          byte_cnt <= '0;
          lat_cnt  <= '0;
        end
        S_CA: if (edge_any) begin
          ca_q     <= ca_full[39:0];
          byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt == 3'd5) begin
            is_read <= ca_full[47];
            is_reg  <= ca_full[46];
            is_lin  <= ca_full[45];
            addr    <= ca_waddr[ADDR_BITS-1:0];
          end
        end
        S_LAT: if (rise) lat_cnt <= lat_cnt + LW'(1);
        S_WDATA: begin
          if (rise) begin
            wr_hi      <= hb.hb_dq_i;
            wr_hi_mask <= hb.hb_rwds_i;
          end else if (fall) begin
            addr <= addr_next;
          end
        end
        S_RDATA: if (fall) addr <= addr_next;
        default: ;
      endcase
    end
  end

  // Array write: the word commits on the fall, each byte gated by its own RWDS mask.
  always_ff @(posedge clk) begin
    if (!clr && !hb.hb_csn_i && (state == S_WDATA) && fall) begin
      if (!wr_hi_mask)    mem[addr][15:8] <= wr_hi;
      if (!hb.hb_rwds_i)  mem[addr][7:0]  <= hb.hb_dq_i;
    end
  end

`ifdef HB_RESP_REG_EN
  // CR0 write: first complete word after a register-write CA wins, later bytes are dropped.
  always_ff @(posedge clk) begin
    if (clr) begin
      cr0      <= CR0_RESET;
      reg_hi   <= 8'h00;
      reg_done <= 1'b0;
    end else if (state == S_IDLE) begin
      reg_done <= 1'b0;
    end else if (!hb.hb_csn_i && (state == S_REGW) && !reg_done) begin
      if (rise) begin
        reg_hi <= hb.hb_dq_i;
      end else if (fall) begin
        cr0      <= {reg_hi, hb.hb_dq_i};
        reg_done <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hb_ram_responder.sv
// Directed bench for hb_ram_responder: drives HyperBus transactions edge by edge and compares
// the DQ/RWDS outputs against a word-level memory/register model on every clk negedge,
// plus literal read-back values for each scenario.
module tb_hb_ram_responder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hb_ram_responder_if hbif();

  hb_ram_responder #(
    .ADDR_BITS(10),
    .LATENCY  (6),
    .ID0_VALUE(16'h0C81),
    .CR0_RESET(16'h8F1F)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .hb    (hbif)
  );

`ifdef HB_RESP_REG_EN
  localparam logic [15:0] EXP_CR0_RST = 16'h8F1F;
  localparam logic [15:0] EXP_CR0_WR  = 16'h8F17;
  localparam logic [15:0] EXP_ID0     = 16'h0C81;
`else
  localparam logic [15:0] EXP_CR0_RST = 16'hFFFF;
  localparam logic [15:0] EXP_CR0_WR  = 16'hFFFF;
  localparam logic [15:0] EXP_ID0     = 16'hFFFF;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_mem [1024];
  logic [15:0] m_cr0 = 16'h8F1F;
  logic [7:0]  e_dq = 8'h00;
  logic        e_dqoe = 1'b0, e_rw = 1'b0, e_rwoe = 1'b0;
  bit          chk_en = 1'b0;
  logic [7:0]  wbyte [32];
  bit          wmsk [32];
  logic [15:0] rd_got [16];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic int next_addr(input int a, input bit lin);
    if (lin) return (a + 1) % 1024;
    return (a / 16) * 16 + ((a + 1) % 16);
  endfunction

  function automatic logic [15:0] model_rd(input bit rs, input int a);
    if (rs) begin
`ifdef HB_RESP_REG_EN
      return (a == 0) ? 16'h0C81 : m_cr0;
`else
      return 16'hFFFF;
`endif
    end
    return model_mem[a];
  endfunction

  // Continuous output compare against the model's expected pins.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("dq_oe", 16'(hbif.hb_dq_oe), 16'(e_dqoe));
      chk("rwds_oe", 16'(hbif.hb_rwds_oe), 16'(e_rwoe));
      if (e_rwoe) chk("rwds_o", 16'(hbif.hb_rwds_o), 16'(e_rw));
      if (e_dqoe) chk("dq_o", 16'(hbif.hb_dq_o), 16'(e_dq));
    end
  end

  // One CK edge: two clk cycles per half period, returns just after the detecting clk edge.
  task automatic hb_edge(input logic ck, input logic [7:0] d, input logic m);
    @(negedge clk);
    @(negedge clk);
    hbif.hb_clk_i  = ck;
    hbif.hb_dq_i   = d;
    hbif.hb_rwds_i = m;
    @(posedge clk);
    #1;
  endtask

  task automatic cs_set(input logic v);
    @(negedge clk);
    @(negedge clk);
    hbif.hb_csn_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [15:0] w);
    wbyte[2*idx]   = w[15:8];
    wbyte[2*idx+1] = w[7:0];
    wmsk[2*idx]    = 1'b0;
    wmsk[2*idx+1]  = 1'b0;
  endtask

  // Full transaction; ndata is the number of data edges (bytes).
  task automatic xfer(input bit rd, input bit rs, input bit lin, input int waddr, input int ndata);
    logic [47:0] ca;
    logic [15:0] w;
    int          a;
    ca        = '0;
    ca[47]    = rd;
    ca[46]    = rs;
    ca[45]    = lin;
    ca[44:16] = 29'(waddr >> 3);
    ca[2:0]   = 3'(waddr);
    cs_set(1'b0);
    e_rwoe = 1'b1; e_rw = 1'b1; e_dqoe = 1'b0;
    for (int i = 0; i < 6; i++) hb_edge((i % 2) == 0, ca[47-8*i -: 8], 1'b0);
    if (!rd && rs) begin
      e_rwoe = 1'b0;
      for (int b = 0; b < ndata; b++) begin
        hb_edge((b % 2) == 0, wbyte[b], wmsk[b]);
        if (b == 1) m_cr0 = {wbyte[0], wbyte[1]};
      end
    end else begin
      for (int k = 0; k < 12; k++) begin
        hb_edge(1'b1, 8'h00, 1'b0);
        hb_edge(1'b0, 8'h00, 1'b0);
      end
      if (!rd) e_rwoe = 1'b0;
      a = waddr % 1024;
      for (int b = 0; b < ndata; b++) begin
        if (rd) begin
          hb_edge((b % 2) == 0, 8'h00, 1'b0);
          w      = model_rd(rs, a);
          e_dqoe = 1'b1;
          e_rw   = ((b % 2) == 0);
          e_dq   = ((b % 2) == 0) ? w[15:8] : w[7:0];
          if ((b % 2) == 0) rd_got[b/2][15:8] = hbif.hb_dq_o;
          else begin
            rd_got[b/2][7:0] = hbif.hb_dq_o;
            a = next_addr(a, lin);
          end
        end else begin
          hb_edge((b % 2) == 0, wbyte[b], wmsk[b]);
          if ((b % 2) == 1) begin
            if (!wmsk[b-1]) model_mem[a][15:8] = wbyte[b-1];
            if (!wmsk[b])   model_mem[a][7:0]  = wbyte[b];
            a = next_addr(a, lin);
          end
        end
      end
    end
    cs_set(1'b1);
    e_dqoe = 1'b0; e_rwoe = 1'b0;
    chk("cs_hi_dq_oe", 16'(hbif.hb_dq_oe), 16'h0);
    chk("cs_hi_rwds_oe", 16'(hbif.hb_rwds_oe), 16'h0);
    if (hbif.hb_clk_i) hb_edge(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    hbif.hb_rstn_i = 1'b1;
    hbif.hb_csn_i  = 1'b1;
    hbif.hb_clk_i  = 1'b0;
    hbif.hb_dq_i   = 8'h00;
    hbif.hb_rwds_i = 1'b0;
    for (int i = 0; i < 32; i++) begin wbyte[i] = 8'h00; wmsk[i] = 1'b0; end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dq_o", 16'(hbif.hb_dq_o), 16'h0);
    chk("rst_dq_oe", 16'(hbif.hb_dq_oe), 16'h0);
    chk("rst_rwds_o", 16'(hbif.hb_rwds_o), 16'h0);
    chk("rst_rwds_oe", 16'(hbif.hb_rwds_oe), 16'h0);
    @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;

    // Linear write/read of four words.
    load(0, 16'h1111); load(1, 16'h2222); load(2, 16'h3333); load(3, 16'h4444);
    xfer(1'b0, 1'b0, 1'b1, 'h010, 8);
    xfer(1'b1, 1'b0, 1'b1, 'h010, 8);
    chk("t1_w0", rd_got[0], 16'h1111);
    chk("t1_w1", rd_got[1], 16'h2222);
    chk("t1_w2", rd_got[2], 16'h3333);
    chk("t1_w3", rd_got[3], 16'h4444);

    // Masked low byte.
    load(0, 16'h0000);
    xfer(1'b0, 1'b0, 1'b1, 'h020, 2);
    load(0, 16'hABCD); wmsk[1] = 1'b1;
    xfer(1'b0, 1'b0, 1'b1, 'h020, 2);
    wmsk[1] = 1'b0;
    xfer(1'b1, 1'b0, 1'b1, 'h020, 2);
    chk("t2_mask", rd_got[0], 16'hAB00);

    // Wrapped read across the 16-word group boundary.
    load(0, 16'h1E1E); load(1, 16'h1F1F);
    xfer(1'b0, 1'b0, 1'b1, 'h01E, 4);
    xfer(1'b1, 1'b0, 1'b0, 'h01E, 8);
    chk("t3_w0", rd_got[0], 16'h1E1E);
    chk("t3_w1", rd_got[1], 16'h1F1F);
    chk("t3_w2", rd_got[2], 16'h1111);
    chk("t3_w3", rd_got[3], 16'h2222);

    // Linear wrap at the top of the array.
    load(0, 16'h3FF3); load(1, 16'h0A0A);
    xfer(1'b0, 1'b0, 1'b1, 'h3FF, 4);
    xfer(1'b1, 1'b0, 1'b1, 'h3FF, 4);
    chk("t4_w0", rd_got[0], 16'h3FF3);
    chk("t4_w1", rd_got[1], 16'h0A0A);

    // Abort after three write bytes: odd byte discarded.
    load(0, 16'h5555); load(1, 16'h5555);
    xfer(1'b0, 1'b0, 1'b1, 'h030, 4);
    load(0, 16'h1234); load(1, 16'h5678);
    xfer(1'b0, 1'b0, 1'b1, 'h030, 3);
    xfer(1'b1, 1'b0, 1'b1, 'h030, 4);
    chk("t5_w0", rd_got[0], 16'h1234);
    chk("t5_w1", rd_got[1], 16'h5555);

    // CS# pulse without CK edges, then CK edges with CS# high.
    cs_set(1'b0);
    e_rwoe = 1'b1; e_rw = 1'b1;
    cs_set(1'b1);
    e_rwoe = 1'b0; e_dqoe = 1'b0;
    hb_edge(1'b1, 8'hFF, 1'b0);
    hb_edge(1'b0, 8'hFF, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 'h030, 2);
    chk("noop_w0", rd_got[0], 16'h1234);

    // Register space.
    xfer(1'b1, 1'b1, 1'b1, 1, 2);
    chk("t6_cr0_rst", rd_got[0], EXP_CR0_RST);
    load(0, 16'h8F17); load(1, 16'h1357);
    xfer(1'b0, 1'b1, 1'b1, 0, 4);
    xfer(1'b1, 1'b1, 1'b1, 1, 2);
    chk("t6_cr0_wr", rd_got[0], EXP_CR0_WR);
    xfer(1'b1, 1'b1, 1'b1, 0, 2);
    chk("t6_id0", rd_got[0], EXP_ID0);

    // HyperBus RST#: CR0 back to reset value, array kept.
    @(negedge clk);
    hbif.hb_rstn_i = 1'b0;
    m_cr0 = 16'h8F1F;
    repeat (3) @(negedge clk);
    chk("hbrst_rwds_o", 16'(hbif.hb_rwds_o), 16'h0);
    hbif.hb_rstn_i = 1'b1;
    xfer(1'b1, 1'b1, 1'b1, 1, 2);
    chk("hbrst_cr0", rd_got[0], EXP_CR0_RST);
    xfer(1'b1, 1'b0, 1'b1, 'h010, 2);
    chk("hbrst_mem", rd_got[0], 16'h1111);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
